// File: rtl/l2_cache_nway_if.sv
// L1-side request/response bus and physical-memory bus of the L2 cache.
// The cache takes the slave view: it serves L1 requests and drives memory.
interface l2_cache_nway_if #(
    parameter int ADDR_BITS = 16,
    parameter int LINE_BITS = 128
);
    logic [ADDR_BITS-1:0]   mem_address;
    logic                   mem_read;
    logic                   mem_write;
    logic [LINE_BITS-1:0]   mem_wdata;
    logic [LINE_BITS/8-1:0] mem_wmask;
    logic [LINE_BITS-1:0]   mem_rdata;
    logic                   mem_resp;

    logic [ADDR_BITS-1:0]   pmem_address;
    logic                   pmem_read;
    logic                   pmem_write;
    logic [LINE_BITS-1:0]   pmem_wdata;
    logic [LINE_BITS-1:0]   pmem_rdata;
    logic                   pmem_resp;

    modport slave (
        input  mem_address, mem_read, mem_write, mem_wdata, mem_wmask,
        input  pmem_rdata, pmem_resp,
        output mem_rdata, mem_resp,
        output pmem_address, pmem_read, pmem_write, pmem_wdata
    );

    modport master (
        output mem_address, mem_read, mem_write, mem_wdata, mem_wmask,
        output pmem_rdata, pmem_resp,
        input  mem_rdata, mem_resp,
        input  pmem_address, pmem_read, pmem_write, pmem_wdata
    );
endinterface

// File: rtl/l2_cache_nway.sv
// N-way set-associative write-back / write-allocate L2 cache with tree
// pseudo-LRU replacement, its own miss controller and saturating counters.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// COMPARE   | lookup; hits answer in the same cycle, misses pick a victim
// WRITEBACK | dirty victim line being written to memory
// FILL      | requested line being read from memory into the victim way
module l2_cache_nway #(
    parameter int WAYS        = 4,
    parameter int INDEX_BITS  = 3,
    parameter int OFFSET_BITS = 4,
    parameter int ADDR_BITS   = 16,
    parameter int LINE_BITS   = 128,
    parameter int CNT_BITS    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    l2_cache_nway_if.slave      bus,
    output logic [CNT_BITS-1:0] hit_count,
    output logic [CNT_BITS-1:0] miss_count,
    output logic [CNT_BITS-1:0] wb_count
);
    localparam int SETS     = 1 << INDEX_BITS;
    localparam int TAG_BITS = ADDR_BITS - INDEX_BITS - OFFSET_BITS;
    localparam int WAY_BITS = $clog2(WAYS);
    localparam int BYTES    = LINE_BITS / 8;

    typedef enum logic [1:0] {COMPARE, WRITEBACK, FILL} state_t;

    state_t                state;
    logic [WAY_BITS-1:0]   victim_q;

    logic [TAG_BITS-1:0]   tag_mem  [WAYS][SETS];
    logic [LINE_BITS-1:0]  data_mem [WAYS][SETS];
    logic [WAYS-1:0]       valid    [SETS];
    logic [WAYS-1:0]       dirty    [SETS];
    logic [WAYS-2:0]       plru     [SETS];

    logic [TAG_BITS-1:0]   tag;
    logic [INDEX_BITS-1:0] idx;
    logic                  req;
    logic                  hit;
    logic [WAY_BITS-1:0]   hit_way;
    logic [WAY_BITS-1:0]   victim_sel;
    logic [WAYS-1:0]       tree;
    logic [WAYS-1:0]       plru_upd;
    logic [LINE_BITS-1:0]  hit_line;
    logic [LINE_BITS-1:0]  merged;
    logic                  hit_req;

    assign tag      = bus.mem_address[ADDR_BITS-1 -: TAG_BITS];
    assign idx      = bus.mem_address[OFFSET_BITS +: INDEX_BITS];
    assign req      = bus.mem_read | bus.mem_write;
    assign tree     = {1'b0, plru[idx]};
    assign hit_line = data_mem[hit_way][idx];
    assign hit_req  = (state == COMPARE) && req && hit;

    assign bus.mem_rdata = hit_line;
    assign bus.mem_resp  = hit_req;

    function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    // Tag compare across all ways of the addressed set.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid[idx][WAY_BITS'(w)] && tag_mem[WAY_BITS'(w)][idx] == tag) begin
                hit     = 1'b1;
                hit_way = WAY_BITS'(w);
            end
        end
    end

    // Victim: lowest invalid way, otherwise follow the PLRU tree from the root.
    always_comb begin
        logic [WAY_BITS:0] node;
        node = '0;
        for (int l = 0; l < WAY_BITS; l++)
            node = {node[WAY_BITS-1:0], 1'b1} + {{WAY_BITS{1'b0}}, tree[node[WAY_BITS-1:0]]};
        victim_sel = WAY_BITS'(node - (WAY_BITS+1)'(WAYS - 1));
        for (int w = WAYS - 1; w >= 0; w--)
            if (!valid[idx][WAY_BITS'(w)]) victim_sel = WAY_BITS'(w);
    end

    // PLRU update for a hit: every node on the path points away from the hit way.
    always_comb begin
        logic [WAY_BITS:0]   node;
        logic [WAY_BITS-1:0] path;
        logic                dir;
        plru_upd = tree;
        node     = '0;
        path     = hit_way;
        for (int l = 0; l < WAY_BITS; l++) begin
            dir                           = path[WAY_BITS-1];
            plru_upd[node[WAY_BITS-1:0]] = ~dir;
            node = {node[WAY_BITS-1:0], 1'b1} + {{WAY_BITS{1'b0}}, dir};
            path = path << 1;
        end
    end

    // Byte-masked merge of the write data into the hit line.
    always_comb begin
        merged = hit_line;
        for (int b = 0; b < BYTES; b++)
            if (bus.mem_wmask[b]) merged[8*b +: 8] = bus.mem_wdata[8*b +: 8];
    end

    // Tag and data arrays carry no reset; valid bits guard their contents.
    always_ff @(posedge clk) begin
        if (hit_req && bus.mem_write) begin
            data_mem[hit_way][idx] <= merged;
        end else if (state == FILL && bus.pmem_resp) begin
            data_mem[victim_q][idx] <= bus.pmem_rdata;
            tag_mem[victim_q][idx]  <= tag;
        end
    end

    // Miss controller, status bits, counters and registered memory-side outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= COMPARE;
            victim_q         <= '0;
            valid            <= '{default: '0};
            dirty            <= '{default: '0};
            plru             <= '{default: '0};
            hit_count        <= '0;
            miss_count       <= '0;
            wb_count         <= '0;
            bus.pmem_read    <= 1'b0;
            bus.pmem_write   <= 1'b0;
            bus.pmem_address <= '0;
            bus.pmem_wdata   <= '0;
        end else begin
            case (state)
                COMPARE: begin
                    if (req && hit) begin
                        hit_count <= sat_inc(hit_count);
                        plru[idx] <= plru_upd[WAYS-2:0];
                        if (bus.mem_write) dirty[idx][hit_way] <= 1'b1;
                    end else if (req) begin
                        miss_count <= sat_inc(miss_count);
                        victim_q   <= victim_sel;
                        if (valid[idx][victim_sel] && dirty[idx][victim_sel]) begin
                            state            <= WRITEBACK;
                            bus.pmem_write   <= 1'b1;
                            bus.pmem_address <= {tag_mem[victim_sel][idx], idx, {OFFSET_BITS{1'b0}}};
                            bus.pmem_wdata   <= data_mem[victim_sel][idx];
                        end else begin
                            state            <= FILL;
                            bus.pmem_read    <= 1'b1;
                            bus.pmem_address <= {tag, idx, {OFFSET_BITS{1'b0}}};
                        end
                    end
                end
                WRITEBACK: begin
                    if (bus.pmem_resp) begin
                        wb_count         <= sat_inc(wb_count);
                        state            <= FILL;
                        bus.pmem_write   <= 1'b0;
                        bus.pmem_read    <= 1'b1;
                        bus.pmem_address <= {tag, idx, {OFFSET_BITS{1'b0}}};
                    end
                end
                FILL: begin
                    if (bus.pmem_resp) begin
                        state                <= COMPARE;
                        bus.pmem_read        <= 1'b0;
                        valid[idx][victim_q] <= 1'b1;
                        dirty[idx][victim_q] <= 1'b0;
                    end
                end
                default: state <= COMPARE;
            endcase
        end
    end
endmodule

// File: tb/tb_l2_cache_nway.sv
// Directed bench for l2_cache_nway: a coherent reference view of memory feeds
// a scoreboard of expected read lines; a simple memory model answers pmem.
module tb_l2_cache_nway;
    localparam int CNT_BITS = 6;
    localparam int MEM_LAT  = 2;
    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

    logic clk = 1'b0;
    logic rst_n;
    logic [CNT_BITS-1:0] hit_count, miss_count, wb_count;

    l2_cache_nway_if #(.ADDR_BITS(16), .LINE_BITS(128)) bus ();

    l2_cache_nway #(
        .WAYS(4), .INDEX_BITS(3), .OFFSET_BITS(4),
        .ADDR_BITS(16), .LINE_BITS(128), .CNT_BITS(CNT_BITS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [127:0] ref_arr  [int];
    logic [127:0] pmem_arr [int];
    logic [127:0] sb_q [$];
    logic [15:0]  op_addr [$];
    bit           op_wr [$];
    int           wr_cycles;
    int           both_cycles;
    int           last_cyc;

    function automatic logic [127:0] default_line(input logic [15:0] a);
        return {8{a & 16'hFFF0}};
    endfunction

    function automatic logic [127:0] ref_get(input logic [15:0] a);
        int k = int'(a & 16'hFFF0);
        return ref_arr.exists(k) ? ref_arr[k] : default_line(a);
    endfunction

    function automatic logic [127:0] pmem_get(input logic [15:0] a);
        int k = int'(a & 16'hFFF0);
        return pmem_arr.exists(k) ? pmem_arr[k] : default_line(a);
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One L1 access; the bench plays memory with fixed latency while waiting.
    task automatic access(input logic [15:0] a, input bit wr,
                          input logic [127:0] wd, input logic [15:0] wm);
        bit done = 0;
        int cyc = 0;
        int busy = 0;
        logic [127:0] line;
        op_addr.delete();
        op_wr.delete();
        wr_cycles   = 0;
        both_cycles = 0;
        bus.mem_address = a;
        bus.mem_read    = !wr;
        bus.mem_write   = wr;
        bus.mem_wdata   = wd;
        bus.mem_wmask   = wm;
        if (!wr) begin
            sb_q.push_back(ref_get(a));
        end else begin
            line = ref_get(a);
            for (int b = 0; b < 16; b++)
                if (wm[b]) line[8*b +: 8] = wd[8*b +: 8];
            ref_arr[int'(a & 16'hFFF0)] = line;
        end
        while (!done && cyc < 200) begin
            #1;
            cyc++;
            if (bus.pmem_write) wr_cycles++;
            if (bus.pmem_read && bus.pmem_write) both_cycles++;
            if (bus.pmem_read || bus.pmem_write) begin
                if (busy == 0) begin
                    op_addr.push_back(bus.pmem_address);
                    op_wr.push_back(bus.pmem_write);
                    if (bus.pmem_write)
                        check("wb_data", bus.pmem_wdata, ref_get(bus.pmem_address));
                end
                busy++;
                if (busy == MEM_LAT) begin
                    if (bus.pmem_write) pmem_arr[int'(bus.pmem_address)] = bus.pmem_wdata;
                    else bus.pmem_rdata = pmem_get(bus.pmem_address);
                    bus.pmem_resp = 1'b1;
                    busy = 0;
                end
            end
            if (bus.mem_resp) begin
                if (!wr) check("rdata", bus.mem_rdata, sb_q.pop_front());
                done = 1;
            end
            @(negedge clk);
            bus.pmem_resp = 1'b0;
        end
        check("resp_seen", 128'(done), 128'd1);
        last_cyc = cyc;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
    endtask

    initial begin
        logic [127:0] merged_line;
        bit seen;
        rst_n            = 1'b0;
        bus.mem_address  = '0;
        bus.mem_read     = 1'b0;
        bus.mem_write    = 1'b0;
        bus.mem_wdata    = '0;
        bus.mem_wmask    = '0;
        bus.pmem_rdata   = '0;
        bus.pmem_resp    = 1'b0;
        ref_arr[16'h1230]  = {16{8'hA5}};
        pmem_arr[16'h1230] = {16{8'hA5}};
        merged_line = {{12{8'hA5}}, {4{8'hFF}}};

        repeat (2) @(negedge clk);
        #1;
        check("rst_mem_resp", 128'(bus.mem_resp), 128'd0);
        check("rst_pmem_read", 128'(bus.pmem_read), 128'd0);
        check("rst_pmem_write", 128'(bus.pmem_write), 128'd0);
        check("rst_counts", {hit_count, miss_count, wb_count}, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Clean miss then hit on the filled line.
        access(16'h1230, 0, '0, '0);
        check("miss1_ops", 128'(op_addr.size()), 128'd1);
        check("miss1_addr", 128'(op_addr[0]), 128'h1230);
        check("miss1_is_read", 128'(op_wr[0]), 128'd0);
        check("miss1_no_write", 128'(wr_cycles), 128'd0);
        check("miss1_latency", 128'(last_cyc), 128'(1 + MEM_LAT + 1));
        check("miss1_miss_count", 128'(miss_count), 128'd1);
        check("miss1_hit_count", 128'(hit_count), 128'd1);

        access(16'h1230, 0, '0, '0);
        check("hit_latency", 128'(last_cyc), 128'd1);
        check("hit_no_ops", 128'(op_addr.size()), 128'd0);
        check("hit_count2", 128'(hit_count), 128'd2);

        // Masked write hit, then read back the merged line.
        access(16'h1230, 1, '1, 16'h000F);
        check("wr_latency", 128'(last_cyc), 128'd1);
        check("wr_no_ops", 128'(op_addr.size()), 128'd0);
        access(16'h1230, 0, '0, '0);
        check("merged_ref", ref_get(16'h1230), merged_line);
        check("hit_count4", 128'(hit_count), 128'd4);

        // Fill the remaining ways, then evict the dirty way 0.
        access(16'h1330, 0, '0, '0);
        access(16'h1430, 0, '0, '0);
        access(16'h1530, 0, '0, '0);
        check("fills_no_wb", 128'(wb_count), 128'd0);
        access(16'h1630, 0, '0, '0);
        check("evict_ops", 128'(op_addr.size()), 128'd2);
        check("evict_wb_addr", 128'(op_addr[0]), 128'h1230);
        check("evict_wb_is_write", 128'(op_wr[0]), 128'd1);
        check("evict_fill_addr", 128'(op_addr[1]), 128'h1630);
        check("evict_fill_is_read", 128'(op_wr[1]), 128'd0);
        check("evict_wb_line", pmem_get(16'h1230), merged_line);
        check("evict_never_both", 128'(both_cycles), 128'd0);
        check("evict_latency", 128'(last_cyc), 128'(1 + 2 * MEM_LAT + 1));
        check("wb_count1", 128'(wb_count), 128'd1);
        check("miss_count5", 128'(miss_count), 128'd5);
        check("hit_count8", 128'(hit_count), 128'd8);

        // Asynchronous reset while a fill is outstanding.
        bus.mem_address = 16'h1730;
        bus.mem_read    = 1'b1;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            #1;
            seen = bus.pmem_read;
        end
        check("abort_pmem_read_seen", 128'(seen), 128'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_pmem_read_drop", 128'(bus.pmem_read), 128'd0);
        check("abort_pmem_write", 128'(bus.pmem_write), 128'd0);
        check("abort_counts", {hit_count, miss_count, wb_count}, 128'd0);
        bus.mem_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        access(16'h1630, 0, '0, '0);
        check("post_rst_ops", 128'(op_addr.size()), 128'd1);
        check("post_rst_addr", 128'(op_addr[0]), 128'h1630);
        check("post_rst_miss", 128'(miss_count), 128'd1);

        // Drive the hit counter to saturation and beyond.
        for (int i = 0; i < int'(CNT_MAX) - 1; i++) access(16'h1630, 0, '0, '0);
        check("hit_sat_reach", 128'(hit_count), 128'(CNT_MAX));
        for (int i = 0; i < 5; i++) access(16'h1630, 0, '0, '0);
        check("hit_sat_hold", 128'(hit_count), 128'(CNT_MAX));
        check("sat_miss_unchanged", 128'(miss_count), 128'd1);
        check("sb_empty", 128'(sb_q.size()), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
